// File: rtl/microsequencer.sv
// Microcoded sequencer: writable store + two opcode dispatch tables, one control word per cycle.
// Define MICROSEQ_WAIT_EN to let microwords with the wait bit stall on mem_ready.
module microsequencer #(
  parameter int CTRL_WIDTH  = 16,
  parameter int UADDR_WIDTH = 4,
  parameter int OP_WIDTH    = 6,
  parameter int FETCH_ADDR  = 0,
  localparam int PA_W = (UADDR_WIDTH > OP_WIDTH) ? UADDR_WIDTH : OP_WIDTH,
  localparam int MW_W = CTRL_WIDTH + 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   halt,
  input  logic [OP_WIDTH-1:0]    opcode,
  input  logic                   mem_ready,
  input  logic                   prog_we,
  input  logic [1:0]             prog_sel,
  input  logic [PA_W-1:0]        prog_addr,
  input  logic [MW_W-1:0]        prog_data,
  output logic [CTRL_WIDTH-1:0]  ctrl,
  output logic [UADDR_WIDTH-1:0] upc,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);
  localparam int UDEPTH = 1 << UADDR_WIDTH;
  localparam int ODEPTH = 1 << OP_WIDTH;
  localparam logic [UADDR_WIDTH-1:0] FETCH_U = UADDR_WIDTH'(FETCH_ADDR);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_ILLEGAL} state_t;

  state_t                 r_state, w_state_nxt;
  logic [UADDR_WIDTH-1:0] r_upc, w_upc_nxt;
  logic                   r_done, w_done_nxt;

  logic [MW_W-1:0]        r_store [UDEPTH];
  logic [UADDR_WIDTH:0]   r_disp1 [ODEPTH];
  logic [UADDR_WIDTH:0]   r_disp2 [ODEPTH];

  logic [MW_W-1:0]        w_mw;
  logic                   w_mw_wait;
  logic [CTRL_WIDTH-1:0]  w_mw_ctrl;
  logic [1:0]             w_mw_seq;
  logic [UADDR_WIDTH:0]   w_disp;
  logic                   w_prog_ok;
  logic                   w_stall;
  logic                   w_active;
  logic                   w_unused;

  // Microword layout: {wait, ctrl, seq[1:0]}
  assign w_mw      = r_store[r_upc];
  assign w_mw_wait = w_mw[MW_W-1];
  assign w_mw_ctrl = w_mw[MW_W-2:2];
  assign w_mw_seq  = w_mw[1:0];
  assign w_disp    = w_mw_seq[1] ? r_disp2[opcode] : r_disp1[opcode];

`ifdef MICROSEQ_WAIT_EN
  assign w_stall = w_mw_wait & ~mem_ready;
`else
  assign w_stall = 1'b0;
`endif
  assign w_unused = &{1'b0, mem_ready, w_mw_wait, prog_addr};

  assign w_prog_ok = prog_we & ((r_state == S_IDLE) | (r_state == S_ILLEGAL));

  // Tables are deliberately outside reset so a restart reuses the loaded program.
  always_ff @(posedge clk) begin
    if (w_prog_ok) begin
      case (prog_sel)
        2'b00:   r_store[prog_addr[UADDR_WIDTH-1:0]] <= prog_data;
        2'b01:   r_disp1[prog_addr[OP_WIDTH-1:0]]    <= prog_data[UADDR_WIDTH:0];
        2'b10:   r_disp2[prog_addr[OP_WIDTH-1:0]]    <= prog_data[UADDR_WIDTH:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_upc   <= FETCH_U;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_upc   <= w_upc_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_upc_nxt   = r_upc;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE, S_ILLEGAL: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_upc_nxt   = FETCH_U;
        end
      end
      S_RUN, S_WAIT: begin
        if (w_stall) begin
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_RUN;
          case (w_mw_seq)
            2'b00: w_upc_nxt = r_upc + UADDR_WIDTH'(1);
            2'b01, 2'b10: begin
              // Invalid dispatch entry parks the machine with upc left pointing at the culprit.
              if (w_disp[UADDR_WIDTH]) begin
                w_upc_nxt = w_disp[UADDR_WIDTH-1:0];
              end else begin
                w_state_nxt = S_ILLEGAL;
              end
            end
            default: begin
              w_upc_nxt  = FETCH_U;
              w_done_nxt = 1'b1;
              if (halt) begin
                w_state_nxt = S_IDLE;
              end
            end
          endcase
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_active = (r_state == S_RUN) | (r_state == S_WAIT);
  assign ctrl     = w_active ? w_mw_ctrl : '0;
  assign upc      = r_upc;
  assign busy     = w_active;
  assign done     = r_done;
  assign err      = (r_state == S_ILLEGAL);

endmodule

// File: tb/tb_microsequencer.sv
// Scoreboard bench for microsequencer; wait-state expectations follow MICROSEQ_WAIT_EN.
module tb_microsequencer;
  logic        clk;
  logic        rst;
  logic        start;
  logic        halt;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        prog_we;
  logic [1:0]  prog_sel;
  logic [5:0]  prog_addr;
  logic [18:0] prog_data;
  logic [15:0] ctrl;
  logic [3:0]  upc;
  logic        busy;
  logic        done;
  logic        err;

  typedef struct packed {
    logic [15:0] ctrl;
    logic [3:0]  upc;
    logic        busy;
    logic        done;
    logic        err;
  } exp_t;

  typedef struct packed {
    logic        start;
    logic        halt;
    logic        mr;
    logic [5:0]  op;
    logic        we;
    logic [1:0]  sel;
    logic [5:0]  addr;
    logic [18:0] dat;
    exp_t        e;
  } stim_t;

  exp_t sb[$];
  int   n_cmp;
  int   n_bad;

  microsequencer dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .opcode(opcode),
    .mem_ready(mem_ready), .prog_we(prog_we), .prog_sel(prog_sel),
    .prog_addr(prog_addr), .prog_data(prog_data), .ctrl(ctrl), .upc(upc),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [18:0] mw(input logic w, input logic [15:0] c, input logic [1:0] sq);
    return {w, c, sq};
  endfunction

  function automatic logic [18:0] de(input logic v, input logic [3:0] t);
    return {14'b0, v, t};
  endfunction

  function automatic stim_t s(input logic st, input logic hl, input logic mr, input logic [5:0] op,
                              input logic [15:0] c, input logic [3:0] u,
                              input logic b, input logic d, input logic er);
    stim_t r;
    r.start = st; r.halt = hl; r.mr = mr; r.op = op;
    r.we = 1'b0; r.sel = 2'b11; r.addr = 6'd0; r.dat = 19'd0;
    r.e = {c, u, b, d, er};
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input stim_t x);
    start = x.start; halt = x.halt; mem_ready = x.mr; opcode = x.op;
    prog_we = x.we; prog_sel = x.sel; prog_addr = x.addr; prog_data = x.dat;
  endtask

  task automatic quiet();
    start = 1'b0; halt = 1'b0; mem_ready = 1'b1; prog_we = 1'b0;
    prog_sel = 2'b11; prog_addr = 6'd0; prog_data = 19'd0;
  endtask

  task automatic prog(input logic [1:0] sel, input logic [5:0] a, input logic [18:0] d);
    prog_we = 1'b1; prog_sel = sel; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic load_program();
    prog(2'b00, 6'd0,  mw(1'b0, 16'h0049, 2'b01));
    prog(2'b01, 6'h23, de(1'b1, 4'd3));
    prog(2'b00, 6'd3,  mw(1'b0, 16'h0008, 2'b11));
    prog(2'b01, 6'h3F, de(1'b0, 4'd0));
    prog(2'b00, 6'd14, mw(1'b0, 16'h00E0, 2'b00));
    prog(2'b00, 6'd15, mw(1'b0, 16'h00F0, 2'b00));
    prog(2'b01, 6'h10, de(1'b1, 4'd14));
    prog(2'b10, 6'h23, de(1'b1, 4'd5));
    prog(2'b00, 6'd5,  mw(1'b0, 16'h0055, 2'b11));
  endtask

  task automatic test_reset();
    exp_t ex, ob;
    rst = 1'b1; quiet(); opcode = 6'd0;
    repeat (2) tick();
    sb.push_back('0);
    ex = sb.pop_front(); ob = {ctrl, upc, busy, done, err}; n_cmp++;
    if (ob !== ex) begin
      n_bad++;
      $display("FAIL reset_hold: got ctrl=%h upc=%0d bde=%b%b%b want ctrl=%h upc=%0d bde=%b%b%b",
               ob.ctrl, ob.upc, ob.busy, ob.done, ob.err, ex.ctrl, ex.upc, ex.busy, ex.done, ex.err);
    end
    rst = 1'b0;
    sb.push_back('0);
    tick();
    ex = sb.pop_front(); ob = {ctrl, upc, busy, done, err}; n_cmp++;
    if (ob !== ex) begin
      n_bad++;
      $display("FAIL reset_release: got ctrl=%h upc=%0d bde=%b%b%b want ctrl=%h upc=%0d bde=%b%b%b",
               ob.ctrl, ob.upc, ob.busy, ob.done, ob.err, ex.ctrl, ex.upc, ex.busy, ex.done, ex.err);
    end
  endtask

  // start held high throughout: it must be ignored once running
  task automatic test_dispatch_loop();
    stim_t q[$]; stim_t st; exp_t ex, ob; int i;
    for (int k = 0; k < 3; k++) begin
      q.push_back(s(1, 0, 1, 6'h23, 16'h0049, 4'd0, 1, (k > 0), 0));
      q.push_back(s(1, 0, 1, 6'h23, 16'h0008, 4'd3, 1, 0, 0));
    end
    i = 0;
    while (q.size() > 0) begin
      st = q.pop_front(); apply(st); sb.push_back(st.e);
      tick();
      ex = sb.pop_front(); ob = {ctrl, upc, busy, done, err}; n_cmp++;
      if (ob !== ex) begin
        n_bad++;
        $display("FAIL dispatch_loop c%0d: got ctrl=%h upc=%0d bde=%b%b%b want ctrl=%h upc=%0d bde=%b%b%b",
                 i, ob.ctrl, ob.upc, ob.busy, ob.done, ob.err, ex.ctrl, ex.upc, ex.busy, ex.done, ex.err);
      end
      i++;
    end
    quiet();
  endtask

  task automatic test_rst_midrun();
    stim_t q[$]; stim_t st; exp_t ex, ob; int i;
    rst = 1'b1;
    sb.push_back('0);
    #1;
    ex = sb.pop_front(); ob = {ctrl, upc, busy, done, err}; n_cmp++;
    if (ob !== ex) begin
      n_bad++;
      $display("FAIL rst_async: got ctrl=%h upc=%0d bde=%b%b%b want ctrl=%h upc=%0d bde=%b%b%b",
               ob.ctrl, ob.upc, ob.busy, ob.done, ob.err, ex.ctrl, ex.upc, ex.busy, ex.done, ex.err);
    end
    sb.push_back('0);
    tick();
    rst = 1'b0;
    ex = sb.pop_front(); ob = {ctrl, upc, busy, done, err}; n_cmp++;
    if (ob !== ex) begin
      n_bad++;
      $display("FAIL rst_no_done: got ctrl=%h upc=%0d bde=%b%b%b want ctrl=%h upc=%0d bde=%b%b%b",
               ob.ctrl, ob.upc, ob.busy, ob.done, ob.err, ex.ctrl, ex.upc, ex.busy, ex.done, ex.err);
    end
    q.push_back(s(1, 0, 1, 6'h23, 16'h0049, 4'd0, 1, 0, 0));
    q.push_back(s(0, 0, 1, 6'h23, 16'h0008, 4'd3, 1, 0, 0));
    i = 0;
    while (q.size() > 0) begin
      st = q.pop_front(); apply(st); sb.push_back(st.e);
      tick();
      ex = sb.pop_front(); ob = {ctrl, upc, busy, done, err}; n_cmp++;
      if (ob !== ex) begin
        n_bad++;
        $display("FAIL rst_restart c%0d: got ctrl=%h upc=%0d bde=%b%b%b want ctrl=%h upc=%0d bde=%b%b%b",
                 i, ob.ctrl, ob.upc, ob.busy, ob.done, ob.err, ex.ctrl, ex.upc, ex.busy, ex.done, ex.err);
      end
      i++;
    end
    quiet();
  endtask

  task automatic test_halt();
    stim_t q[$]; stim_t st; exp_t ex, ob; int i;
    q.push_back(s(0, 1, 1, 6'h23, 16'h0000, 4'd0, 0, 1, 0));
    q.push_back(s(0, 0, 1, 6'h23, 16'h0000, 4'd0, 0, 0, 0));
    q.push_back(s(1, 1, 1, 6'h23, 16'h0049, 4'd0, 1, 0, 0));
    q.push_back(s(0, 1, 1, 6'h23, 16'h0008, 4'd3, 1, 0, 0));
    q.push_back(s(0, 1, 1, 6'h23, 16'h0000, 4'd0, 0, 1, 0));
    q.push_back(s(0, 0, 1, 6'h23, 16'h0000, 4'd0, 0, 0, 0));
    i = 0;
    while (q.size() > 0) begin
      st = q.pop_front(); apply(st); sb.push_back(st.e);
      tick();
      ex = sb.pop_front(); ob = {ctrl, upc, busy, done, err}; n_cmp++;
      if (ob !== ex) begin
        n_bad++;
        $display("FAIL halt c%0d: got ctrl=%h upc=%0d bde=%b%b%b want ctrl=%h upc=%0d bde=%b%b%b",
                 i, ob.ctrl, ob.upc, ob.busy, ob.done, ob.err, ex.ctrl, ex.upc, ex.busy, ex.done, ex.err);
      end
      i++;
    end
    quiet();
  endtask

  task automatic test_illegal();
    stim_t q[$]; stim_t st; exp_t ex, ob; int i;
    q.push_back(s(1, 0, 1, 6'h3F, 16'h0049, 4'd0, 1, 0, 0));
    st = s(0, 0, 1, 6'h3F, 16'h0000, 4'd0, 0, 0, 1);
    st.we = 1'b1; st.sel = 2'b00; st.addr = 6'd3; st.dat = mw(1'b0, 16'hBEEF, 2'b11);
    q.push_back(st);
    q.push_back(s(0, 0, 1, 6'h3F, 16'h0000, 4'd0, 0, 0, 1));
    st = s(0, 0, 1, 6'h3F, 16'h0000, 4'd0, 0, 0, 1);
    st.we = 1'b1; st.sel = 2'b01; st.addr = 6'h3F; st.dat = de(1'b1, 4'd3);
    q.push_back(st);
    q.push_back(s(1, 0, 1, 6'h3F, 16'h0049, 4'd0, 1, 0, 0));
    q.push_back(s(0, 0, 1, 6'h3F, 16'h0008, 4'd3, 1, 0, 0));
    q.push_back(s(0, 1, 1, 6'h3F, 16'h0000, 4'd0, 0, 1, 0));
    i = 0;
    while (q.size() > 0) begin
      st = q.pop_front(); apply(st); sb.push_back(st.e);
      tick();
      ex = sb.pop_front(); ob = {ctrl, upc, busy, done, err}; n_cmp++;
      if (ob !== ex) begin
        n_bad++;
        $display("FAIL illegal c%0d: got ctrl=%h upc=%0d bde=%b%b%b want ctrl=%h upc=%0d bde=%b%b%b",
                 i, ob.ctrl, ob.upc, ob.busy, ob.done, ob.err, ex.ctrl, ex.upc, ex.busy, ex.done, ex.err);
      end
      i++;
    end
    quiet();
  endtask

  task automatic test_wrap();
    stim_t q[$]; stim_t st; exp_t ex, ob; int i;
    q.push_back(s(1, 0, 1, 6'h10, 16'h0049, 4'd0,  1, 0, 0));
    q.push_back(s(0, 0, 1, 6'h10, 16'h00E0, 4'd14, 1, 0, 0));
    q.push_back(s(0, 0, 1, 6'h10, 16'h00F0, 4'd15, 1, 0, 0));
    q.push_back(s(0, 0, 1, 6'h23, 16'h0049, 4'd0,  1, 0, 0));
    q.push_back(s(0, 0, 1, 6'h23, 16'h0008, 4'd3,  1, 0, 0));
    q.push_back(s(0, 1, 1, 6'h23, 16'h0000, 4'd0,  0, 1, 0));
    i = 0;
    while (q.size() > 0) begin
      st = q.pop_front(); apply(st); sb.push_back(st.e);
      tick();
      ex = sb.pop_front(); ob = {ctrl, upc, busy, done, err}; n_cmp++;
      if (ob !== ex) begin
        n_bad++;
        $display("FAIL wrap c%0d: got ctrl=%h upc=%0d bde=%b%b%b want ctrl=%h upc=%0d bde=%b%b%b",
                 i, ob.ctrl, ob.upc, ob.busy, ob.done, ob.err, ex.ctrl, ex.upc, ex.busy, ex.done, ex.err);
      end
      i++;
    end
    quiet();
  endtask

  // Write coinciding with start: first RUN cycle must already show the new fetch word.
  task automatic test_dispatch2();
    stim_t q[$]; stim_t st; exp_t ex, ob; int i;
    st = s(1, 0, 1, 6'h23, 16'h0A49, 4'd0, 1, 0, 0);
    st.we = 1'b1; st.sel = 2'b00; st.addr = 6'd0; st.dat = mw(1'b0, 16'h0A49, 2'b10);
    q.push_back(st);
    q.push_back(s(0, 0, 1, 6'h23, 16'h0055, 4'd5, 1, 0, 0));
    q.push_back(s(0, 1, 1, 6'h23, 16'h0000, 4'd0, 0, 1, 0));
    st = s(0, 0, 1, 6'h23, 16'h0000, 4'd0, 0, 0, 0);
    st.we = 1'b1; st.sel = 2'b00; st.addr = 6'd0; st.dat = mw(1'b0, 16'h0049, 2'b01);
    q.push_back(st);
    i = 0;
    while (q.size() > 0) begin
      st = q.pop_front(); apply(st); sb.push_back(st.e);
      tick();
      ex = sb.pop_front(); ob = {ctrl, upc, busy, done, err}; n_cmp++;
      if (ob !== ex) begin
        n_bad++;
        $display("FAIL dispatch2 c%0d: got ctrl=%h upc=%0d bde=%b%b%b want ctrl=%h upc=%0d bde=%b%b%b",
                 i, ob.ctrl, ob.upc, ob.busy, ob.done, ob.err, ex.ctrl, ex.upc, ex.busy, ex.done, ex.err);
      end
      i++;
    end
    quiet();
  endtask

  task automatic test_wait();
    stim_t q[$]; stim_t st; exp_t ex, ob; int i;
    st = s(0, 0, 1, 6'h23, 16'h0000, 4'd0, 0, 0, 0);
    st.we = 1'b1; st.sel = 2'b00; st.addr = 6'd3; st.dat = mw(1'b1, 16'h0008, 2'b11);
    q.push_back(st);
    q.push_back(s(1, 0, 0, 6'h23, 16'h0049, 4'd0, 1, 0, 0));
    q.push_back(s(0, 0, 0, 6'h23, 16'h0008, 4'd3, 1, 0, 0));
`ifdef MICROSEQ_WAIT_EN
    q.push_back(s(0, 0, 0, 6'h23, 16'h0008, 4'd3, 1, 0, 0));
    q.push_back(s(0, 0, 0, 6'h23, 16'h0008, 4'd3, 1, 0, 0));
    q.push_back(s(0, 0, 0, 6'h23, 16'h0008, 4'd3, 1, 0, 0));
    q.push_back(s(0, 0, 1, 6'h23, 16'h0049, 4'd0, 1, 1, 0));
    q.push_back(s(0, 0, 1, 6'h23, 16'h0008, 4'd3, 1, 0, 0));
    q.push_back(s(0, 0, 1, 6'h23, 16'h0049, 4'd0, 1, 1, 0));
    q.push_back(s(0, 0, 1, 6'h23, 16'h0008, 4'd3, 1, 0, 0));
`else
    q.push_back(s(0, 0, 0, 6'h23, 16'h0049, 4'd0, 1, 1, 0));
    q.push_back(s(0, 0, 0, 6'h23, 16'h0008, 4'd3, 1, 0, 0));
    q.push_back(s(0, 0, 0, 6'h23, 16'h0049, 4'd0, 1, 1, 0));
    q.push_back(s(0, 0, 1, 6'h23, 16'h0008, 4'd3, 1, 0, 0));
`endif
    q.push_back(s(0, 1, 1, 6'h23, 16'h0000, 4'd0, 0, 1, 0));
    i = 0;
    while (q.size() > 0) begin
      st = q.pop_front(); apply(st); sb.push_back(st.e);
      tick();
      ex = sb.pop_front(); ob = {ctrl, upc, busy, done, err}; n_cmp++;
      if (ob !== ex) begin
        n_bad++;
        $display("FAIL wait c%0d: got ctrl=%h upc=%0d bde=%b%b%b want ctrl=%h upc=%0d bde=%b%b%b",
                 i, ob.ctrl, ob.upc, ob.busy, ob.done, ob.err, ex.ctrl, ex.upc, ex.busy, ex.done, ex.err);
      end
      i++;
    end
    quiet();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    load_program();
    test_dispatch_loop();
    test_rst_midrun();
    test_halt();
    test_illegal();
    test_wrap();
    test_dispatch2();
    test_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
